// File: rtl/pointing_port_scheduler.sv
// Merges two pointing-device byte streams onto one paced serial stream.
// Bytes are buffered per port; only whole packets are forwarded, round-robin.
module pointing_port_scheduler #(
  parameter int FIFO_DEPTH      = 8,
  parameter int TICKS_NORMAL    = 250000,
  parameter int TICKS_OVERCLOCK = 200000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rts,
  input  logic       overclock,
  input  logic       in0_write,
  input  logic [7:0] in0_data,
  input  logic       in1_write,
  input  logic [7:0] in1_data,
  output logic [1:0] rts_out,
  output logic       out_write,
  output logic [7:0] out_data,
  output logic       active_port,
  output logic [1:0] overflow
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TMAX = (TICKS_NORMAL > TICKS_OVERCLOCK) ? TICKS_NORMAL : TICKS_OVERCLOCK;
  localparam int GW   = $clog2(TMAX) + 1;

  localparam logic [AW:0]   DEPTH_P    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   PTR_ONE    = (AW+1)'(1);
  localparam logic [GW-1:0] GAP_ONE    = GW'(1);
  localparam logic [GW-1:0] GAP_NORMAL = GW'(TICKS_NORMAL - 1);
  localparam logic [GW-1:0] GAP_OVER   = GW'(TICKS_OVERCLOCK - 1);

  typedef enum logic {PH_ID, PH_DATA} phase_t;
  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_WAIT} sched_t;

  logic [7:0]  mem     [2][FIFO_DEPTH];
  logic [AW:0] wr_ptr  [2];
  logic [AW:0] cm_ptr  [2];
  logic [AW:0] rd_ptr  [2];
  logic [AW:0] pkt_cnt [2];
  phase_t      phase   [2];
  logic [1:0]  idx     [2];
  logic [1:0]  drop;
  logic [1:0]  id_pend;

  logic [1:0]  in_write;
  logic [7:0]  in_data [2];
  logic [1:0]  wr_req, full, last, accept, ovf_hit, commit, pop, done, avail;

  sched_t      state, state_n;
  logic [GW-1:0] gap, gap_n;
  logic [1:0]  remaining, rem_n;
  logic        sel_n, last_grant, lg_n, grant;
  logic [7:0]  data_hold;
  logic [7:0]  head;

  assign rts_out    = {rts, rts};
  assign in_write   = {in1_write, in0_write};
  assign in_data[0] = in0_data;
  assign in_data[1] = in1_data;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      wr_req[p]  = in_write[p] & ~rts;
      full[p]    = (wr_ptr[p] - rd_ptr[p]) == DEPTH_P;
      last[p]    = (phase[p] == PH_ID) || (idx[p] == 2'd2);
      accept[p]  = wr_req[p] & ~drop[p] & ~full[p];
      ovf_hit[p] = wr_req[p] & ~drop[p] & full[p];
      commit[p]  = accept[p] & last[p];
      pop[p]     = (state == S_EMIT) && (active_port == 1'(p));
      done[p]    = pop[p] && (remaining == 2'd1);
      avail[p]   = pkt_cnt[p] != '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < 2; p++) begin
      if (accept[p]) mem[p][wr_ptr[p][AW-1:0]] <= in_data[p];
    end
  end

  // A write into a full FIFO rewinds to the last commit point and swallows
  // the rest of that packet; the index keeps counting so framing stays aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned p = 0; p < 2; p++) begin
        wr_ptr[p]  <= '0;
        cm_ptr[p]  <= '0;
        rd_ptr[p]  <= '0;
        pkt_cnt[p] <= '0;
        phase[p]   <= PH_ID;
        idx[p]     <= '0;
      end
      drop     <= '0;
      id_pend  <= '0;
      overflow <= '0;
    end else if (rts) begin
      for (int unsigned p = 0; p < 2; p++) begin
        wr_ptr[p]  <= '0;
        cm_ptr[p]  <= '0;
        rd_ptr[p]  <= '0;
        pkt_cnt[p] <= '0;
        phase[p]   <= PH_ID;
        idx[p]     <= '0;
      end
      drop     <= '0;
      id_pend  <= '0;
      overflow <= '0;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (accept[p]) begin
          wr_ptr[p] <= wr_ptr[p] + PTR_ONE;
          if (last[p]) cm_ptr[p] <= wr_ptr[p] + PTR_ONE;
        end else if (ovf_hit[p]) begin
          wr_ptr[p]   <= cm_ptr[p];
          overflow[p] <= 1'b1;
          if (!last[p]) drop[p] <= 1'b1;
        end

        if (wr_req[p]) begin
          if (phase[p] == PH_ID) begin
            if (accept[p]) phase[p] <= PH_DATA;
          end else begin
            idx[p] <= (idx[p] == 2'd2) ? 2'd0 : idx[p] + 2'd1;
            if (idx[p] == 2'd2) drop[p] <= 1'b0;
          end
        end

        if (pop[p]) rd_ptr[p] <= rd_ptr[p] + PTR_ONE;
        pkt_cnt[p] <= pkt_cnt[p] + {{AW{1'b0}}, commit[p]} - {{AW{1'b0}}, done[p]};

        if (commit[p] && (phase[p] == PH_ID)) id_pend[p] <= 1'b1;
        else if (done[p])                     id_pend[p] <= 1'b0;
      end
    end
  end

  // IDLE grants one cycle before the gap would reach zero so the first byte of
  // the next packet lands exactly one period after the previous byte.
  always_comb begin
    state_n = state;
    gap_n   = gap;
    rem_n   = remaining;
    sel_n   = active_port;
    lg_n    = last_grant;
    grant   = 1'b0;
    case (state)
      S_IDLE: begin
        if (gap != '0) gap_n = gap - GAP_ONE;
        if ((gap <= GAP_ONE) && (avail != 2'b00)) begin
          grant   = (avail == 2'b11) ? ~last_grant : avail[1];
          sel_n   = grant;
          lg_n    = grant;
          rem_n   = id_pend[grant] ? 2'd1 : 2'd3;
          state_n = S_EMIT;
        end
      end
      S_EMIT: begin
        gap_n   = overclock ? GAP_OVER : GAP_NORMAL;
        rem_n   = remaining - 2'd1;
        state_n = (remaining == 2'd1) ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (gap != '0) gap_n = gap - GAP_ONE;
        if (gap <= GAP_ONE) state_n = S_EMIT;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      gap         <= '0;
      remaining   <= '0;
      active_port <= 1'b0;
      last_grant  <= 1'b1;
    end else if (rts) begin
      state     <= S_IDLE;
      gap       <= '0;
      remaining <= '0;
    end else begin
      state       <= state_n;
      gap         <= gap_n;
      remaining   <= rem_n;
      active_port <= sel_n;
      last_grant  <= lg_n;
    end
  end

  assign head      = mem[active_port][rd_ptr[active_port][AW-1:0]];
  assign out_write = (state == S_EMIT) && !rts;
  assign out_data  = out_write ? head : data_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       data_hold <= '0;
    else if (out_write) data_hold <= head;
  end

endmodule

// File: tb/tb_pointing_port_scheduler.sv
// Bench for pointing_port_scheduler: packet vectors plus an output scoreboard
// that checks byte order, source port and pulse spacing.
module tb_pointing_port_scheduler;

  logic       clk = 1'b0;
  logic       reset_n, rts, overclock;
  logic       in0_write, in1_write;
  logic [7:0] in0_data, in1_data;
  logic [1:0] rts_out, overflow;
  logic       out_write, active_port;
  logic [7:0] out_data;

  pointing_port_scheduler #(
    .FIFO_DEPTH     (4),
    .TICKS_NORMAL   (8),
    .TICKS_OVERCLOCK(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rts        (rts),
    .overclock  (overclock),
    .in0_write  (in0_write),
    .in0_data   (in0_data),
    .in1_write  (in1_write),
    .in1_data   (in1_data),
    .rts_out    (rts_out),
    .out_write  (out_write),
    .out_data   (out_data),
    .active_port(active_port),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        port;
    int unsigned gap;
  } exp_t;

  typedef struct {
    logic        port;
    logic [7:0]  b0, b1, b2;
    logic        oc;
    int unsigned gap;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[6];
  int unsigned checks = 0, failures = 0;
  int unsigned cyc = 0, pulses = 0, last_pulse = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n === 1'b1 && out_write === 1'b1) begin
      pulses++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual=%02h port=%0d required=none", out_data, active_port);
      end else begin
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("active_port", 32'(active_port), 32'(e.port));
        if (e.gap != 0) check("spacing", cyc - last_pulse, e.gap);
      end
      last_pulse = cyc;
    end
  end

  task automatic push(input logic [7:0] d, input logic p, input int unsigned g);
    exp_t e;
    e.data = d;
    e.port = p;
    e.gap  = g;
    sb.push_back(e);
  endtask

  task automatic drive(input logic w0, input logic [7:0] d0, input logic w1, input logic [7:0] d1);
    in0_write = w0;
    in0_data  = d0;
    in1_write = w1;
    in1_data  = d1;
    @(negedge clk);
    in0_write = 1'b0;
    in1_write = 1'b0;
  endtask

  task automatic send(input logic p, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    drive(!p, a, p, a);
    drive(!p, b, p, b);
    drive(!p, c, p, c);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_write(input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_write !== 1'b1 && n < max);
    if (out_write !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL wait_write_timeout actual=0 required=1");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0, p0;

    tbl[0] = '{1'b0, 8'h11, 8'h22, 8'h33, 1'b0, 8};
    tbl[1] = '{1'b1, 8'h44, 8'h55, 8'h66, 1'b0, 8};
    tbl[2] = '{1'b0, 8'h77, 8'h88, 8'h99, 1'b1, 4};
    tbl[3] = '{1'b1, 8'hAA, 8'hBB, 8'hCC, 1'b1, 4};
    tbl[4] = '{1'b0, 8'h01, 8'hFE, 8'h80, 1'b0, 8};
    tbl[5] = '{1'b1, 8'hFF, 8'h00, 8'h7F, 1'b1, 4};

    reset_n = 1'b0; rts = 1'b0; overclock = 1'b0;
    in0_write = 1'b0; in1_write = 1'b0; in0_data = '0; in1_data = '0;
    #1;
    check("reset_out_write", 32'(out_write), 0);
    check("reset_out_data", 32'(out_data), 0);
    check("reset_active_port", 32'(active_port), 0);
    check("reset_overflow", 32'(overflow), 0);
    idle(2);
    reset_n = 1'b1;

    // 1: ID then data packet on port 0, with commit-to-write latency
    rts = 1'b1;
    @(negedge clk);
    check("rts_out_high", 32'(rts_out), 32'h3);
    @(negedge clk);
    rts = 1'b0;
    #1;
    check("rts_out_low", 32'(rts_out), 0);
    idle(5);
    push(8'hCA, 1'b0, 0); push(8'hC0, 1'b0, 8); push(8'h82, 1'b0, 8); push(8'h81, 1'b0, 8);
    c0 = cyc;
    drive(1'b1, 8'hCA, 1'b0, 8'h00);
    drive(1'b1, 8'hC0, 1'b0, 8'h00);
    check("latency_cycles", cyc - c0, 2);
    check("latency_write", 32'(out_write), 1);
    drive(1'b1, 8'h82, 1'b0, 8'h00);
    drive(1'b1, 8'h81, 1'b0, 8'h00);
    drain(200);
    check("t1_active_port", 32'(active_port), 0);
    check("t1_overflow", 32'(overflow), 0);

    // 2: ID on port 1, then simultaneous commits twice
    idle(10);
    push(8'hE1, 1'b1, 0);
    drive(1'b0, 8'h00, 1'b1, 8'hE1);
    drain(100);
    idle(10);
    push(8'hC0, 1'b0, 0); push(8'h81, 1'b0, 8); push(8'h82, 1'b0, 8);
    push(8'hC4, 1'b1, 8); push(8'h90, 1'b1, 8); push(8'hA0, 1'b1, 8);
    drive(1'b1, 8'hC0, 1'b1, 8'hC4);
    drive(1'b1, 8'h81, 1'b1, 8'h90);
    drive(1'b1, 8'h82, 1'b1, 8'hA0);
    drain(200);
    idle(10);
    push(8'hA1, 1'b0, 0); push(8'hA2, 1'b0, 8); push(8'hA3, 1'b0, 8);
    push(8'hB4, 1'b1, 8); push(8'hB5, 1'b1, 8); push(8'hB6, 1'b1, 8);
    drive(1'b1, 8'hA1, 1'b1, 8'hB4);
    drive(1'b1, 8'hA2, 1'b1, 8'hB5);
    drive(1'b1, 8'hA3, 1'b1, 8'hB6);
    drain(200);

    // packet vectors
    for (int i = 0; i < 6; i++) begin
      overclock = tbl[i].oc;
      idle(10);
      push(tbl[i].b0, tbl[i].port, 0);
      push(tbl[i].b1, tbl[i].port, tbl[i].gap);
      push(tbl[i].b2, tbl[i].port, tbl[i].gap);
      send(tbl[i].port, tbl[i].b0, tbl[i].b1, tbl[i].b2);
      drain(100);
      check("tbl_active_port", 32'(active_port), 32'(tbl[i].port));
    end
    overclock = 1'b0;
    check("tbl_overflow", 32'(overflow), 0);

    // 3: overclock raised mid-packet
    idle(10);
    push(8'hD1, 1'b0, 0); push(8'hD2, 1'b0, 8); push(8'hD3, 1'b0, 4);
    send(1'b0, 8'hD1, 8'hD2, 8'hD3);
    wait_write(50);
    @(negedge clk);
    overclock = 1'b1;
    drain(100);
    overclock = 1'b0;

    // 4: port 1 flood while port 0 is being emitted
    idle(12);
    push(8'hE0, 1'b0, 0); push(8'hE1, 1'b0, 8); push(8'hE2, 1'b0, 8);
    push(8'h10, 1'b1, 8); push(8'h11, 1'b1, 8); push(8'h12, 1'b1, 8);
    send(1'b0, 8'hE0, 8'hE1, 8'hE2);
    send(1'b1, 8'h10, 8'h11, 8'h12);
    send(1'b1, 8'h20, 8'h21, 8'h22);
    check("t4_overflow_set", 32'(overflow), 32'h2);
    drain(200);
    push(8'h30, 1'b1, 0); push(8'h31, 1'b1, 8); push(8'h32, 1'b1, 8);
    send(1'b1, 8'h30, 8'h31, 8'h32);
    drain(100);
    idle(12);
    check("t4_overflow_sticky", 32'(overflow), 32'h2);

    // 5: rts mid-packet
    push(8'hF1, 1'b0, 0);
    send(1'b0, 8'hF1, 8'hF2, 8'hF3);
    wait_write(50);
    @(negedge clk);
    rts = 1'b1;
    @(negedge clk);
    check("t5_overflow_cleared", 32'(overflow), 0);
    check("t5_rts_out", 32'(rts_out), 32'h3);
    drive(1'b1, 8'hEE, 1'b0, 8'h00);
    rts = 1'b0;
    p0 = pulses;
    idle(30);
    check("t5_no_write_after_rts", pulses, p0);
    push(8'hA5, 1'b0, 0);
    drive(1'b1, 8'hA5, 1'b0, 8'h00);
    drain(50);
    idle(10);
    push(8'h5A, 1'b1, 0);
    drive(1'b0, 8'h00, 1'b1, 8'h5A);
    drain(50);
    idle(10);
    push(8'h31, 1'b0, 0); push(8'h32, 1'b0, 8); push(8'h33, 1'b0, 8);
    send(1'b0, 8'h31, 8'h32, 8'h33);
    drain(100);

    // 6: asynchronous reset during WAIT
    idle(10);
    push(8'hB1, 1'b1, 0);
    send(1'b1, 8'hB1, 8'hB2, 8'hB3);
    wait_write(50);
    idle(3);
    check("t6_hold_data", 32'(out_data), 32'hB1);
    check("t6_hold_port", 32'(active_port), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_out_write", 32'(out_write), 0);
    check("t6_async_out_data", 32'(out_data), 0);
    check("t6_async_active_port", 32'(active_port), 0);
    check("t6_async_overflow", 32'(overflow), 0);
    sb.delete();
    idle(2);
    reset_n = 1'b1;
    idle(3);
    push(8'h77, 1'b1, 0);
    drive(1'b0, 8'h00, 1'b1, 8'h77);
    drain(50);
    idle(10);
    push(8'h66, 1'b0, 0);
    drive(1'b1, 8'h66, 1'b0, 8'h00);
    drain(50);
    idle(10);
    push(8'h01, 1'b0, 0); push(8'h02, 1'b0, 8); push(8'h03, 1'b0, 8);
    send(1'b0, 8'h01, 8'h02, 8'h03);
    drain(100);
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
